// File: rtl/connect4_pkg.sv
// Shared board geometry, payload types and FSM state encoding for the Connect-4 datapath.
package connect4_pkg;

    localparam int unsigned ROWS     = 6;
    localparam int unsigned COLS     = 7;
    localparam int unsigned CELLS    = ROWS * COLS;
    localparam int unsigned LAST_IDX = CELLS - 1;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned POS_W    = 3;
    localparam int unsigned DIR_W    = 2;

    // Row 0 is the bottom row; index as board[row][col].
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [DIR_W-1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D  = 2'd2,
        DIR_AD = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } wc_state_t;

endpackage

// File: rtl/line4_match.sv
// Combinational four-in-a-line test for one anchor cell in all four directions.
module line4_match
    import connect4_pkg::*;
(
    input  board_t           board,
    input  logic [POS_W-1:0] row,
    input  logic [POS_W-1:0] col,
    output logic             hit,
    output dir_t             dir
);

    logic [3:0] match;

    // Walk k = 0..3 from the anchor; any step off the board kills that direction.
    always_comb begin : match_p
        int r;
        int c;
        int dr;
        int dc;
        match = '0;
        r     = 0;
        c     = 0;
        dr    = 0;
        dc    = 0;
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin dr = 0; dc = 1;  end
                1:       begin dr = 1; dc = 0;  end
                2:       begin dr = 1; dc = 1;  end
                default: begin dr = 1; dc = -1; end
            endcase
            match[d] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                r = int'(row) + dr * k;
                c = int'(col) + dc * k;
                if (r < 0 || r >= int'(ROWS) || c < 0 || c >= int'(COLS)) begin
                    match[d] = 1'b0;
                end else if (!board[3'(r)][3'(c)]) begin
                    match[d] = 1'b0;
                end
            end
        end
    end

    // Lower direction code wins when several lines share the anchor.
    always_comb begin
        hit = |match;
        dir = DIR_H;
        if (match[0])      dir = DIR_H;
        else if (match[1]) dir = DIR_V;
        else if (match[2]) dir = DIR_D;
        else if (match[3]) dir = DIR_AD;
    end

endmodule

// File: rtl/win_check.sv
// Sequential win/draw scanner: snapshots both boards on start and tests one anchor per cycle.
module win_check
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             player,
    input  board_t           board0,
    input  board_t           board1,
    output logic             busy,
    output logic             done,
    output logic             win,
    output logic             draw,
    output logic [POS_W-1:0] winRow,
    output logic [POS_W-1:0] winCol,
    output logic [DIR_W-1:0] winDir
);

    wc_state_t        state_q,   state_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [POS_W-1:0] arow_q,    arow_d;
    logic [POS_W-1:0] acol_q,    acol_d;
    board_t           snap0_q,   snap0_d;
    board_t           snap1_q,   snap1_d;
    logic             player_q,  player_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             win_q,     win_d;
    logic             draw_q,    draw_d;
    logic [POS_W-1:0] win_row_q, win_row_d;
    logic [POS_W-1:0] win_col_q, win_col_d;
    dir_t             win_dir_q, win_dir_d;

    board_t sel_board;
    logic   anchor_hit;
    dir_t   anchor_dir;

    assign sel_board = player_q ? snap1_q : snap0_q;

    line4_match u_line4_match (
        .board (sel_board),
        .row   (arow_q),
        .col   (acol_q),
        .hit   (anchor_hit),
        .dir   (anchor_dir)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            arow_q    <= '0;
            acol_q    <= '0;
            snap0_q   <= '0;
            snap1_q   <= '0;
            player_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            draw_q    <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
            win_dir_q <= DIR_H;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            arow_q    <= arow_d;
            acol_q    <= acol_d;
            snap0_q   <= snap0_d;
            snap1_q   <= snap1_d;
            player_q  <= player_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_q     <= win_d;
            draw_q    <= draw_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            win_dir_q <= win_dir_d;
        end
    end

    // Next-state: accept start in IDLE, early-exit on first hit, draw decision at the last anchor.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        arow_d    = arow_q;
        acol_d    = acol_q;
        snap0_d   = snap0_q;
        snap1_d   = snap1_q;
        player_d  = player_q;
        win_d     = win_q;
        draw_d    = draw_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        win_dir_d = win_dir_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap0_d   = board0;
                    snap1_d   = board1;
                    player_d  = player;
                    win_d     = 1'b0;
                    draw_d    = 1'b0;
                    win_row_d = '0;
                    win_col_d = '0;
                    win_dir_d = DIR_H;
                    idx_d     = '0;
                    arow_d    = '0;
                    acol_d    = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (anchor_hit) begin
                    win_d     = 1'b1;
                    win_row_d = arow_q;
                    win_col_d = acol_q;
                    win_dir_d = anchor_dir;
                    state_d   = ST_REPORT;
                end else if (idx_q == IDX_W'(LAST_IDX)) begin
                    win_d   = 1'b0;
                    draw_d  = &(snap0_q | snap1_q);
                    state_d = ST_REPORT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (acol_q == POS_W'(COLS - 1)) begin
                        acol_d = '0;
                        arow_d = arow_q + POS_W'(1);
                    end else begin
                        acol_d = acol_q + POS_W'(1);
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_REPORT);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign win    = win_q;
    assign draw   = draw_q;
    assign winRow = win_row_q;
    assign winCol = win_col_q;
    assign winDir = win_dir_q;

endmodule

// File: doc/win_check.md
WIN_CHECK -- requirements
Module: win_check

Interface
REQ-001 The block SHALL have no parameters; board dimensions come from connect4_pkg (ROWS=6, COLS=7).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; returns the block to IDLE.
REQ-004 start  input  1  request a scan; sampled only in IDLE (driven from the drop stage's dropDone).
REQ-005 player  input  1  board to test: 0 = board0, 1 = board1.
REQ-006 board0  input  [5:0][6:0]  player-0 occupancy; row 0 is the bottom row, row 5 the top row.
REQ-007 board1  input  [5:0][6:0]  player-1 occupancy; same layout as board0.
REQ-008 busy  output  1  high from the accepted start edge through the REPORT cycle.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 win  output  1  the selected player has four in a line.
REQ-011 draw  output  1  no win and all 42 cells are occupied.
REQ-012 winRow  output  3  anchor row of the winning line; 0 when win=0.
REQ-013 winCol  output  3  anchor column of the winning line; 0 when win=0.
REQ-014 winDir  output  2  direction of the winning line: 0 = horizontal (col+k), 1 = vertical (row+k), 2 = diagonal (row+k, col+k), 3 = anti-diagonal (row+k, col-k).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN, REPORT.
REQ-016 IDLE: on a clock edge with start=1, snapshot board0, board1 and player, clear win/draw/winRow/winCol/winDir, set anchor index to 0, go to SCAN.
REQ-017 The scan SHALL ignore board and player changes after the snapshot edge.
REQ-018 SCAN: evaluate one anchor per cycle; idx = row*7 + col, row-major from (0,0) to (5,6).
REQ-019 Per anchor, test the four directions over offsets k = 0..3 on the selected board only.
  - Any cell outside rows 0..5 or cols 0..6 means that direction does not match.
  - Direction priority when several match: 0 > 1 > 2 > 3.
REQ-020 On the first matching anchor: latch win=1, winRow, winCol and winDir, go to REPORT; remaining anchors are not scanned (early exit).
REQ-021 At idx=41 with no match: latch draw = AND of (board0 | board1) over all 42 snapshot cells, win=0, go to REPORT.
REQ-022 REPORT: done=1 for exactly one cycle, then go to IDLE.
REQ-023 win, draw, winRow, winCol and winDir SHALL hold their values until the next accepted start.
REQ-024 Latency: with start accepted at edge E0 and the match at idx k, done SHALL be high in the cycle after edge E0+k+1. With no match, done SHALL be high in the cycle after edge E0+42.
REQ-025 start during SCAN or REPORT SHALL be ignored and not queued.
REQ-026 win and draw SHALL never both be 1.
REQ-027 A cell set in both boards SHALL count as occupied for draw and as owned by each board for its own win test.
REQ-028 The anchor index SHALL be 6 bits and SHALL NOT wrap; SCAN exits at 41.

Reset
REQ-029 On reset: state=IDLE, idx=0, busy=0, done=0, win=0, draw=0, winRow=0, winCol=0, winDir=0, snapshot cleared.
REQ-030 Reset asserted mid-SCAN or in REPORT SHALL abort the scan with no done pulse.
REQ-031 After reset deasserts, the first start SHALL be accepted.

Structure
REQ-032 connect4_pkg SHALL hold ROWS, COLS, board_t ([5:0][6:0] logic), dir_t (H, V, D, AD) and the win_check state enum.
REQ-033 The per-anchor four-direction match SHALL be one combinational sub-module, line4_match.
  - Inputs: board_t, row, col.
  - Outputs: hit, dir.
REQ-034 The FSM, snapshot registers and index counter SHALL live in win_check.

Verification
REQ-035 player=0; board0 row 0 cols 0..3 set; start -> done one cycle after E0+1; win=1, winRow=0, winCol=0, winDir=0, draw=0.
REQ-036 player=1; board1 col 6 rows 0..3 set; board0 row 1 cols 0..3 also set -> win=1, (0,6), winDir=1 (idx 6); board0's line is ignored.
REQ-037 player=0; board0 cells (0,3), (1,2), (2,1), (3,0) set -> win=1, (0,3), winDir=3; done one cycle after E0+4.
REQ-038 Full board with no four-in-line for player 1; player=1 -> win=0, draw=1; done one cycle after E0+42; busy high for 43 cycles.
REQ-039 start re-pulsed at E0+5 during SCAN -> no restart and the same result and timing as without it. Reset at E0+10 -> busy=0, no done, all outputs 0.
REQ-040 Board changed at E0+1 to add a winning line -> result reflects only the snapshot taken at E0 (win=0 for an empty snapshot).
